// File: rtl/rgb_pwm_blinker.sv
// ---------------------------------------------------------------------------
// rgb_pwm_blinker
//
// Per-channel PWM driver for the on-board RGB LED. It sits between the top
// level and the LED driver pins. It has four runtime modes:
//   0 OFF      all channels dark
//   1 BLINK    binary blink taken straight from the high bits of step_cnt
//   2 BREATHE  all three channels follow one triangle brightness ramp
//   3 RAINBOW  three triangle ramps, each shifted by one third of the cycle
//
// Timebase:
//   - pwm_cnt runs freely. One PWM period is 2^PWM_W clocks.
//   - presc_cnt counts PWM periods, 0..PRESC_DIV-1.
//   - step_cnt advances once every PRESC_DIV periods and sets brightness.
//
// The selected mode is captured only at a PWM period boundary. A mode change
// therefore never produces a partial period.
//
// Optional feature (macro RGB_PWM_GAMMA_EN):
//   - BREATHE and RAINBOW levels pass through a square-law gamma curve.
//   - One extra pipeline stage is added, so pin latency becomes 2 clocks for
//     every mode.
//   - With the macro undefined, levels are linear and pin latency is 1 clock.
// ---------------------------------------------------------------------------
module rgb_pwm_blinker #(
    parameter int PWM_W     = 8,
    parameter int PRESC_DIV = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    output logic       led_red,
    output logic       led_green,
    output logic       led_blue,
    output logic       step_tick
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_BLINK   = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic [1:0] MODE_RAINBOW = 2'd3;

    // A divider of 1 still needs a one-bit counter, which stays parked at 0.
    localparam int PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

    localparam logic [PWM_W-1:0]   PWM_MAX    = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0]   PWM_ONE    = PWM_W'(1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
    localparam logic [PWM_W:0]     STEP_ONE   = (PWM_W + 1)'(1);

    // Rainbow phase offsets: one third and two thirds of the step cycle.
    // The adders below wrap modulo 2^(PWM_W+1) by construction.
    localparam logic [PWM_W:0] OFS1 = (PWM_W + 1)'((2 ** (PWM_W + 1)) / 3);
    localparam logic [PWM_W:0] OFS2 = (PWM_W + 1)'(2 * ((2 ** (PWM_W + 1)) / 3));

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Fold a (PWM_W+1)-bit ramp into a triangle 0 .. 2^PWM_W-1 .. 0.
    function automatic logic [PWM_W-1:0] tri_f(input logic [PWM_W:0] x);
        logic [PWM_W-1:0] r;
        if (x[PWM_W]) begin
            r = ~x[PWM_W-1:0];
        end else begin
            r = x[PWM_W-1:0];
        end
        return r;
    endfunction

    // PWM comparator: the channel is on while the level exceeds the counter.
    // A level of 0 is therefore always off.
    function automatic logic pwm_on_f(input logic [PWM_W-1:0] level,
                                      input logic [PWM_W-1:0] cnt);
        return (level > cnt);
    endfunction

`ifdef RGB_PWM_GAMMA_EN
    // Square-law gamma: (x*x) >> PWM_W, computed at full double width.
    function automatic logic [PWM_W-1:0] gamma_f(input logic [PWM_W-1:0] x);
        logic [2*PWM_W-1:0] sq;
        sq = {{PWM_W{1'b0}}, x} * {{PWM_W{1'b0}}, x};
        return PWM_W'(sq >> PWM_W);
    endfunction
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PWM_W-1:0]   pwm_cnt_q,   pwm_cnt_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [PWM_W:0]     step_cnt_q,  step_cnt_d;
    logic [1:0]         mode_q,      mode_d;
    logic               step_tick_q, step_tick_d;
    logic               led_red_q,   led_red_d;
    logic               led_green_q, led_green_d;
    logic               led_blue_q,  led_blue_d;

    logic               per_end_s;
    logic               step_adv_s;

    // Per-channel level and blink-bypass selection, before the pin stage.
    logic [PWM_W-1:0]   lvl_red_s, lvl_green_s, lvl_blue_s;
    logic               bypass_s;
    logic [2:0]         blink_s;
    logic [PWM_W:0]     step_ofs1_s, step_ofs2_s;

`ifdef RGB_PWM_GAMMA_EN
    // Extra stage: gamma-corrected levels plus aligned counter and blink.
    logic [PWM_W-1:0]   lvl_red_q,   lvl_red_d;
    logic [PWM_W-1:0]   lvl_green_q, lvl_green_d;
    logic [PWM_W-1:0]   lvl_blue_q,  lvl_blue_d;
    logic [PWM_W-1:0]   pwm_dly_q,   pwm_dly_d;
    logic               bypass_q,    bypass_d;
    logic [2:0]         blink_q,     blink_d;
`endif

    // Timebase next-state: PWM counter, prescaler, step counter, mode capture.
    always_comb begin
        pwm_cnt_d   = pwm_cnt_q + PWM_ONE;
        presc_cnt_d = presc_cnt_q;
        step_cnt_d  = step_cnt_q;
        mode_d      = mode_q;

        per_end_s  = (pwm_cnt_q == PWM_MAX);
        step_adv_s = per_end_s && (presc_cnt_q == PRESC_LAST);

        if (per_end_s) begin
            mode_d = mode;
            if (presc_cnt_q == PRESC_LAST) begin
                presc_cnt_d = {PRESC_W{1'b0}};
            end else begin
                presc_cnt_d = presc_cnt_q + PRESC_ONE;
            end
        end else begin
            mode_d      = mode_q;
            presc_cnt_d = presc_cnt_q;
        end

        if (step_adv_s) begin
            step_cnt_d = step_cnt_q + STEP_ONE;
        end else begin
            step_cnt_d = step_cnt_q;
        end

        step_tick_d = step_adv_s;
    end

    // Brightness level for each channel according to the captured mode.
    always_comb begin
        lvl_red_s   = {PWM_W{1'b0}};
        lvl_green_s = {PWM_W{1'b0}};
        lvl_blue_s  = {PWM_W{1'b0}};
        bypass_s    = 1'b0;
        blink_s     = 3'b000;
        step_ofs1_s = step_cnt_q + OFS1;
        step_ofs2_s = step_cnt_q + OFS2;

        case (mode_q)
            MODE_OFF: begin
                bypass_s = 1'b0;
            end
            MODE_BLINK: begin
                // BLINK bypasses the PWM and drives the pins from step bits.
                bypass_s = 1'b1;
                blink_s  = {step_cnt_q[PWM_W], step_cnt_q[PWM_W-1],
                            step_cnt_q[PWM_W-2]};
            end
            MODE_BREATHE: begin
                lvl_red_s   = tri_f(step_cnt_q);
                lvl_green_s = tri_f(step_cnt_q);
                lvl_blue_s  = tri_f(step_cnt_q);
            end
            MODE_RAINBOW: begin
                lvl_red_s   = tri_f(step_cnt_q);
                lvl_green_s = tri_f(step_ofs1_s);
                lvl_blue_s  = tri_f(step_ofs2_s);
            end
            default: begin
                bypass_s = 1'b0;
            end
        endcase
    end

`ifdef RGB_PWM_GAMMA_EN
    // Gamma stage inputs: curve the levels and keep pwm_cnt aligned with them.
    always_comb begin
        lvl_red_d   = gamma_f(lvl_red_s);
        lvl_green_d = gamma_f(lvl_green_s);
        lvl_blue_d  = gamma_f(lvl_blue_s);
        pwm_dly_d   = pwm_cnt_q;
        bypass_d    = bypass_s;
        blink_d     = blink_s;
    end

    // Pin stage (gamma build): compare the delayed level against the delayed counter.
    always_comb begin
        led_red_d   = 1'b0;
        led_green_d = 1'b0;
        led_blue_d  = 1'b0;
        if (bypass_q) begin
            led_red_d   = blink_q[2];
            led_green_d = blink_q[1];
            led_blue_d  = blink_q[0];
        end else begin
            led_red_d   = pwm_on_f(lvl_red_q,   pwm_dly_q);
            led_green_d = pwm_on_f(lvl_green_q, pwm_dly_q);
            led_blue_d  = pwm_on_f(lvl_blue_q,  pwm_dly_q);
        end
    end

    // Gamma pipeline registers; synchronous reset clears them with the rest.
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_red_q   <= {PWM_W{1'b0}};
            lvl_green_q <= {PWM_W{1'b0}};
            lvl_blue_q  <= {PWM_W{1'b0}};
            pwm_dly_q   <= {PWM_W{1'b0}};
            bypass_q    <= 1'b0;
            blink_q     <= 3'b000;
        end else begin
            lvl_red_q   <= lvl_red_d;
            lvl_green_q <= lvl_green_d;
            lvl_blue_q  <= lvl_blue_d;
            pwm_dly_q   <= pwm_dly_d;
            bypass_q    <= bypass_d;
            blink_q     <= blink_d;
        end
    end
`else
    // Pin stage (linear build): compare the level against the live counter.
    always_comb begin
        led_red_d   = 1'b0;
        led_green_d = 1'b0;
        led_blue_d  = 1'b0;
        if (bypass_s) begin
            led_red_d   = blink_s[2];
            led_green_d = blink_s[1];
            led_blue_d  = blink_s[0];
        end else begin
            led_red_d   = pwm_on_f(lvl_red_s,   pwm_cnt_q);
            led_green_d = pwm_on_f(lvl_green_s, pwm_cnt_q);
            led_blue_d  = pwm_on_f(lvl_blue_s,  pwm_cnt_q);
        end
    end
`endif

    // Counters, mode capture and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q   <= {PWM_W{1'b0}};
            presc_cnt_q <= {PRESC_W{1'b0}};
            step_cnt_q  <= {(PWM_W + 1){1'b0}};
            mode_q      <= MODE_OFF;
            step_tick_q <= 1'b0;
            led_red_q   <= 1'b0;
            led_green_q <= 1'b0;
            led_blue_q  <= 1'b0;
        end else begin
            pwm_cnt_q   <= pwm_cnt_d;
            presc_cnt_q <= presc_cnt_d;
            step_cnt_q  <= step_cnt_d;
            mode_q      <= mode_d;
            step_tick_q <= step_tick_d;
            led_red_q   <= led_red_d;
            led_green_q <= led_green_d;
            led_blue_q  <= led_blue_d;
        end
    end

    assign led_red   = led_red_q;
    assign led_green = led_green_q;
    assign led_blue  = led_blue_q;
    assign step_tick = step_tick_q;

endmodule

// File: tb/tb_rgb_pwm_blinker.sv
// ---------------------------------------------------------------------------
// tb_rgb_pwm_blinker
//
// Directed bench for rgb_pwm_blinker at PWM_W=4, PRESC_DIV=2:
//   - one PWM period is 16 clocks;
//   - step_cnt advances every 32 clocks.
//
// n counts clock edges since reset release. After edge n the counters hold:
//   pwm_cnt  = n % 16
//   step_cnt = (n / 32) % 32
// An LED observed after edge n reflects the counter state of edge n-LAT.
// ---------------------------------------------------------------------------
module tb_rgb_pwm_blinker;

`ifdef RGB_PWM_GAMMA_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       led_red;
    logic       led_green;
    logic       led_blue;
    logic       step_tick;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    rgb_pwm_blinker #(
        .PWM_W     (4),
        .PRESC_DIV (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .led_red   (led_red),
        .led_green (led_green),
        .led_blue  (led_blue),
        .step_tick (step_tick)
    );

    always #5 clk = ~clk;

    // Expected PWM level after the optional gamma curve (PWM_W = 4).
    function automatic int lvl(input int lin);
`ifdef RGB_PWM_GAMMA_EN
        return (lin * lin) >> 4;
`else
        return lin;
`endif
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, obs, exp);
        end
    endtask

    // One clock edge; inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    // Advance to edge count 'target'; the target is always a bounded step ahead.
    task automatic goto(input int target);
        if (target < n) begin
            total++;
            bad++;
            $error("FAIL goto n=%0d observed=%0d expected>=%0d", n, n, target);
        end else begin
            while (n < target) tick();
        end
    endtask

    // Hold reset 3 cycles with mode=2, release, then check the dark start and
    // the first step_tick 32 cycles after release.
    task automatic reset_release();
        reset = 1'b1;
        mode  = 2'd2;
        repeat (3) begin
            tick();
            chk("rst_hold", {led_red, led_green, led_blue, step_tick}, 4'b0000);
        end
        reset = 1'b0;
        n = 0;
        for (int i = 1; i <= 33; i++) begin
            tick();
            if (i <= 16) chk("post_rst_dark", {led_red, led_green, led_blue, 1'b0}, 4'b0000);
            chk("step_tick", {3'b000, step_tick}, {3'b000, (i == 32)});
        end
    endtask

    // Check one full PWM period of step S, half h (0 or 1), cycle by cycle.
    task automatic win(input string tag, input int s, input int h,
                       input int lr, input int lg, input int lb);
        int base;
        base = 32 * s + 16 * h;
        for (int k = 0; k < 16; k++) begin
            goto(base + k + LAT);
            chk(tag, {led_red, led_green, led_blue, 1'b0},
                {(k < lr), (k < lg), (k < lb), 1'b0});
        end
    endtask

    // Single-point check of the three LEDs at step S, pwm position p.
    task automatic pt(input string tag, input int s, input int p, input logic [2:0] exp);
        goto(32 * s + p + LAT);
        chk(tag, {led_red, led_green, led_blue, 1'b0}, {exp, 1'b0});
    endtask

    initial begin
        int base;
        reset = 1'b1;
        mode  = 2'd2;

        // Reset and first step_tick.
        reset_release();

        // BREATHE: tri(5)=5, tri(15)=15, tri(20)=11, tri(31)=0.
        win("breathe_s5",  5,  1, lvl(5),  lvl(5),  lvl(5));
        win("breathe_s15", 15, 1, lvl(15), lvl(15), lvl(15));
        win("breathe_s20", 20, 1, lvl(11), lvl(11), lvl(11));
        win("breathe_s31", 31, 1, 0, 0, 0);

        // BLINK: r=step[4], g=step[3], b=step[2].
        mode = 2'd1;
        pt("blink_s1",  33, 7,  3'b000);
        pt("blink_s4",  36, 7,  3'b001);
        pt("blink_s8",  40, 7,  3'b010);
        pt("blink_s12", 44, 7,  3'b011);
        pt("blink_s16", 48, 7,  3'b100);
        pt("blink_s31", 63, 15, 3'b111);

        // RAINBOW at step 0: red tri(0)=0, green tri(10)=10, blue tri(20)=11.
        mode = 2'd3;
        win("rainbow_s0", 64, 0, lvl(0), lvl(10), lvl(11));

        // BREATHE at step 14 (level 14), then switch to OFF at pwm_cnt=5.
        // The current period must complete; the next one must be dark.
        mode = 2'd2;
        base = 32 * 78 + 16;
        for (int k = 0; k < 32; k++) begin
            goto(base + k + LAT);
            if (k < 16) begin
                chk("mode_chg_hold", {led_red, led_green, led_blue, 1'b0},
                    {(k < lvl(14)), (k < lvl(14)), (k < lvl(14)), 1'b0});
            end else begin
                chk("mode_chg_off", {led_red, led_green, led_blue, 1'b0}, 4'b0000);
            end
            if (n == base + 5) mode = 2'd0;
        end

        // BREATHE again; at step 17 (level 14) mid-period, assert reset.
        mode = 2'd2;
        pt("pre_reset_s17", 81, 22, 3'b111);
        reset_release();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
